// File: rtl/rv_fetch_pkg.sv
// Shared widths and the fetch-queue entry type for the instruction-fetch stage.
package rv_fetch_pkg;

   localparam int unsigned XLEN = 64;
   localparam int unsigned ILEN = 32;

   localparam logic [ILEN-1:0] NOP_INST = 32'h00000013;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [ILEN-1:0] inst;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO of fetched {pc, inst} entries. The head is read straight
// from registered storage; flush empties the queue and overrides push/pop.
module fetch_queue
   import rv_fetch_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rstn,
   input  logic                     push,
   input  fetch_entry_t             push_data,
   input  logic                     pop,
   input  logic                     flush,
   output fetch_entry_t             head,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   fetch_entry_t   mem_q [DEPTH];
   fetch_entry_t   mem_d [DEPTH];
   logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]  count_q, count_d;

   // Next-state for storage, pointers and occupancy.
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + AW'(1);
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
         end
         case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
         endcase
      end
   end

   // State registers; storage is cleared on reset so the head reads zero.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         mem_q    <= '{default: '0};
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Upstream credit accounting must never let a push land on a full queue.
   always_ff @(posedge clk) begin
      if (rstn && push && !pop && !flush) begin
         assert (count_q != CW'(DEPTH));
      end
   end

   // Head and occupancy outputs.
   always_comb begin
      head  = mem_q[rd_ptr_q];
      count = count_q;
   end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: generates the PC, issues word reads to the
// instruction memory, buffers responses and hands them to decode. A redirect
// from execute flushes the queue and drops any response already in flight.
module if_fetch_unit
   import rv_fetch_pkg::*;
#(
   parameter int unsigned     DEPTH    = 4,
   parameter logic [XLEN-1:0] RESET_PC = '0
) (
   input  logic             clk,
   input  logic             rstn,
   output logic             imem_req,
   output logic [XLEN-1:0]  imem_addr,
   input  logic [ILEN-1:0]  imem_rdata,
   input  logic             redirect_valid,
   input  logic [XLEN-1:0]  redirect_pc,
   output logic             id_valid,
   input  logic             id_ready,
   output logic [ILEN-1:0]  id_inst,
   output logic [XLEN-1:0]  id_pc
);

   localparam int unsigned CW  = $clog2(DEPTH) + 1;
   localparam int unsigned CW1 = CW + 1;

   logic [XLEN-1:0] pc_q, pc_d;
   logic [XLEN-1:0] req_pc_q, req_pc_d;
   logic            inflight_q, inflight_d;
   logic            kill_q, kill_d;

   logic [CW-1:0]   q_count;
   fetch_entry_t    q_head;
   fetch_entry_t    q_push_data;
   logic            q_push;
   logic            q_pop;
   logic            deq;
   logic            issue;
   logic [CW1-1:0]  credit_used;
   logic            unused_redirect_lsbs;

   // Handshake, credit check and issue decision.
   always_comb begin
      id_valid    = (q_count != '0);
      deq         = id_valid & id_ready;
      // Slots already committed: occupied, plus one arriving, minus one leaving.
      credit_used = CW1'(q_count) + CW1'(inflight_q) - CW1'(deq);
      issue       = rstn & ~redirect_valid & (credit_used < CW1'(DEPTH));
      imem_req    = issue;
      imem_addr   = pc_q;
      q_push      = inflight_q & ~kill_q;
      q_pop       = deq;
      q_push_data = '{pc: req_pc_q, inst: imem_rdata};
      id_inst     = q_head.inst;
      id_pc       = q_head.pc;
      unused_redirect_lsbs = ^redirect_pc[1:0];
   end

   // PC, request-tracking and kill next-state; redirect takes priority.
   always_comb begin
      pc_d       = pc_q;
      req_pc_d   = req_pc_q;
      inflight_d = issue;
      kill_d     = 1'b0;
      if (redirect_valid) begin
         pc_d   = {redirect_pc[XLEN-1:2], 2'b00};
         kill_d = inflight_q;
      end else if (issue) begin
         pc_d     = pc_q + XLEN'(4);
         req_pc_d = pc_q;
      end
   end

   // Fetch state registers.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         pc_q       <= RESET_PC;
         req_pc_q   <= '0;
         inflight_q <= 1'b0;
         kill_q     <= 1'b0;
      end else begin
         pc_q       <= pc_d;
         req_pc_q   <= req_pc_d;
         inflight_q <= inflight_d;
         kill_q     <= kill_d;
      end
   end

   fetch_queue #(
      .DEPTH (DEPTH)
   ) u_queue (
      .clk       (clk),
      .rstn      (rstn),
      .push      (q_push),
      .push_data (q_push_data),
      .pop       (q_pop),
      .flush     (redirect_valid),
      .head      (q_head),
      .count     (q_count)
   );

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit with a scoreboard of expected decode PCs.
module tb_if_fetch_unit;
   import rv_fetch_pkg::*;

   logic            clk = 1'b0;
   logic            rstn;
   logic            imem_req;
   logic [XLEN-1:0] imem_addr;
   logic [ILEN-1:0] imem_rdata;
   logic            redirect_valid;
   logic [XLEN-1:0] redirect_pc;
   logic            id_valid;
   logic            id_ready;
   logic [ILEN-1:0] id_inst;
   logic [XLEN-1:0] id_pc;

   int unsigned n_assert = 0;
   int unsigned n_fail   = 0;
   logic [XLEN-1:0] exp_q [$];

   always #5 clk = ~clk;

   if_fetch_unit #(
      .DEPTH    (4),
      .RESET_PC (64'h0)
   ) dut (
      .clk            (clk),
      .rstn           (rstn),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_rdata     (imem_rdata),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .id_valid       (id_valid),
      .id_ready       (id_ready),
      .id_inst        (id_inst),
      .id_pc          (id_pc)
   );

   function automatic logic [ILEN-1:0] inst_of(input logic [XLEN-1:0] a);
      if (a == 64'h0)      return 32'h00108093;
      else if (a == 64'h4) return 32'h00230313;
      else                 return {16'hC0DE, a[15:0]};
   endfunction

   // Instruction memory: one-cycle read latency.
   always @(posedge clk) begin
      imem_rdata <= imem_req ? inst_of(imem_addr) : 32'hDEADBEEF;
   end

   task automatic chk(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Scoreboard: every decode handshake consumes the next expected PC.
   always @(negedge clk) begin
      if (rstn === 1'b1 && id_valid === 1'b1 && id_ready === 1'b1 && exp_q.size() != 0) begin
         logic [XLEN-1:0] e;
         e = exp_q.pop_front();
         chk("sb_pc", id_pc, e);
         chk("sb_inst", {32'h0, id_inst}, {32'h0, inst_of(e)});
      end
   end

   task automatic next();
      @(posedge clk);
      #1;
   endtask

   task automatic samp();
      @(negedge clk);
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_req"},   {63'h0, imem_req}, 64'h0);
      chk({tag, "_addr"},  imem_addr, 64'h0);
      chk({tag, "_valid"}, {63'h0, id_valid}, 64'h0);
      chk({tag, "_inst"},  {32'h0, id_inst}, 64'h0);
      chk({tag, "_pc"},    id_pc, 64'h0);
   endtask

   // Holds reset for two cycles, then releases it just after an edge (cycle C0).
   task automatic do_reset(input logic ready);
      exp_q.delete();
      rstn           = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      id_ready       = ready;
      samp();
      check_reset_outputs("rst");
      next();
      next();
      rstn = 1'b1;
   endtask

   task automatic drain_check(input string tag, input int unsigned cycles);
      for (int unsigned i = 0; i < cycles; i++) next();
      samp();
      chk(tag, 64'(exp_q.size()), 64'h0);
   endtask

   int unsigned n_req;
   logic [XLEN-1:0] max_addr;

   initial begin
      // Stream from reset with decode always ready.
      do_reset(1'b1);
      for (int unsigned i = 0; i < 8; i++) exp_q.push_back(64'(i * 4));
      samp();
      chk("p1_first_req", {63'h0, imem_req}, 64'h1);
      chk("p1_first_addr", imem_addr, 64'h0);
      chk("p1_c0_valid", {63'h0, id_valid}, 64'h0);
      next(); samp();
      chk("p1_c1_valid", {63'h0, id_valid}, 64'h0);
      chk("p1_c1_addr", imem_addr, 64'h4);
      next(); samp();
      chk("p1_c2_valid", {63'h0, id_valid}, 64'h1);
      chk("p1_c2_pc", id_pc, 64'h0);
      chk("p1_c2_inst", {32'h0, id_inst}, 64'h00108093);
      for (int unsigned i = 0; i < 7; i++) begin
         next(); samp();
         chk("p1_nogap", {63'h0, id_valid}, 64'h1);
      end
      drain_check("p1_drain", 1);

      // Decode stalled from reset: issue stops once four slots are committed.
      do_reset(1'b0);
      n_req    = 0;
      max_addr = '0;
      for (int unsigned i = 0; i < 8; i++) begin
         samp();
         if (imem_req) begin
            n_req++;
            if (imem_addr > max_addr) max_addr = imem_addr;
         end
         next();
      end
      samp();
      chk("p2_req_count", 64'(n_req), 64'h4);
      chk("p2_max_addr", max_addr, 64'hC);
      chk("p2_full_req", {63'h0, imem_req}, 64'h0);
      chk("p2_head_valid", {63'h0, id_valid}, 64'h1);
      chk("p2_head_pc", id_pc, 64'h0);
      chk("p2_head_inst", {32'h0, id_inst}, 64'h00108093);
      for (int unsigned i = 0; i < 6; i++) exp_q.push_back(64'(i * 4));
      next();
      id_ready = 1'b1;
      drain_check("p2_drain", 10);

      // Redirect while the request to 0x10 is in flight.
      do_reset(1'b1);
      exp_q.push_back(64'h0);  exp_q.push_back(64'h4);  exp_q.push_back(64'h8);
      exp_q.push_back(64'hC);  exp_q.push_back(64'h14); exp_q.push_back(64'h18);
      exp_q.push_back(64'h1C);
      for (int unsigned i = 0; i < 4; i++) next();
      samp();
      chk("p3_c4_addr", imem_addr, 64'h10);
      chk("p3_c4_req", {63'h0, imem_req}, 64'h1);
      next();
      redirect_valid = 1'b1;
      redirect_pc    = 64'h14;
      samp();
      chk("p3_redir_req", {63'h0, imem_req}, 64'h0);
      chk("p3_redir_head", id_pc, 64'hC);
      next();
      redirect_valid = 1'b0;
      samp();
      chk("p3_empty", {63'h0, id_valid}, 64'h0);
      chk("p3_tgt_req", {63'h0, imem_req}, 64'h1);
      chk("p3_tgt_addr", imem_addr, 64'h14);
      next(); samp();
      chk("p3_r2_valid", {63'h0, id_valid}, 64'h0);
      next(); samp();
      chk("p3_r3_valid", {63'h0, id_valid}, 64'h1);
      chk("p3_r3_pc", id_pc, 64'h14);
      drain_check("p3_drain", 4);

      // Redirect during a handshake, then a second redirect the next cycle.
      do_reset(1'b1);
      exp_q.push_back(64'h0);  exp_q.push_back(64'h4);  exp_q.push_back(64'h8);
      exp_q.push_back(64'h40); exp_q.push_back(64'h44); exp_q.push_back(64'h48);
      for (int unsigned i = 0; i < 4; i++) next();
      redirect_valid = 1'b1;
      redirect_pc    = 64'h20;
      samp();
      chk("p4_hs_valid", {63'h0, id_valid}, 64'h1);
      chk("p4_hs_pc", id_pc, 64'h8);
      next();
      redirect_pc = 64'h40;
      samp();
      chk("p4_r2_valid", {63'h0, id_valid}, 64'h0);
      chk("p4_r2_req", {63'h0, imem_req}, 64'h0);
      next();
      redirect_valid = 1'b0;
      samp();
      chk("p4_tgt_valid", {63'h0, id_valid}, 64'h0);
      chk("p4_tgt_addr", imem_addr, 64'h40);
      chk("p4_tgt_req", {63'h0, imem_req}, 64'h1);
      next(); samp();
      chk("p4_gap_valid", {63'h0, id_valid}, 64'h0);
      next(); samp();
      chk("p4_first_pc", id_pc, 64'h40);
      drain_check("p4_drain", 4);

      // Misaligned redirect target, then a redirect that wraps the PC.
      do_reset(1'b1);
      exp_q.push_back(64'h0);  exp_q.push_back(64'h18);
      exp_q.push_back(64'h1C); exp_q.push_back(64'h20);
      next(); next();
      redirect_valid = 1'b1;
      redirect_pc    = 64'h1B;
      samp();
      chk("p5_hs_pc", id_pc, 64'h0);
      next();
      redirect_valid = 1'b0;
      samp();
      chk("p5_align_addr", imem_addr, 64'h18);
      next(); next(); samp();
      chk("p5_align_pc", id_pc, 64'h18);
      drain_check("p5_drain", 4);
      exp_q.delete();
      next();
      id_ready       = 1'b0;
      redirect_valid = 1'b1;
      redirect_pc    = '1;
      exp_q.push_back(64'hFFFF_FFFF_FFFF_FFFC);
      exp_q.push_back(64'h0);
      next();
      redirect_valid = 1'b0;
      id_ready       = 1'b1;
      samp();
      chk("p5_top_addr", imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
      next(); samp();
      chk("p5_wrap_addr", imem_addr, 64'h0);
      drain_check("p5_wrap_drain", 5);

      // Reset mid-stream with three entries queued and one in flight.
      do_reset(1'b0);
      for (int unsigned i = 0; i < 4; i++) next();
      samp();
      chk("p6_pre_valid", {63'h0, id_valid}, 64'h1);
      chk("p6_pre_req", {63'h0, imem_req}, 64'h0);
      #2;
      rstn = 1'b0;
      #1;
      check_reset_outputs("p6_async");
      next();
      rstn     = 1'b1;
      id_ready = 1'b1;
      exp_q.push_back(64'h0); exp_q.push_back(64'h4); exp_q.push_back(64'h8);
      samp();
      chk("p6_restart_req", {63'h0, imem_req}, 64'h1);
      chk("p6_restart_addr", imem_addr, 64'h0);
      next(); next(); samp();
      chk("p6_restart_pc", id_pc, 64'h0);
      drain_check("p6_drain", 3);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
